imem_responder: RTL and testbench
=================================

IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 Parameter ADDR_WIDTH, default 11, word address width (2^ADDR_WIDTH words).
REQ-002 Parameter DATA_WIDTH, default 32, word width.
REQ-003 Parameter CLEAR_ON_RESET, default 1, zero-fill the array after reset when 1.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 mem_rd  input  1  read request, sampled at rising edge.
REQ-007 mem_rd_addr  input  ADDR_WIDTH  read word address.
REQ-008 mem_rd_data  output  DATA_WIDTH  registered read data.
REQ-009 mem_rd_valid  output  1  mem_rd_data carries a new read result this cycle.
REQ-010 mem_wr  input  1  write request, sampled at rising edge.
REQ-011 mem_wr_addr  input  ADDR_WIDTH  write word address.
REQ-012 mem_wr_data  input  DATA_WIDTH  write data.
REQ-013 busy  output  1  responder cannot accept requests this cycle.
REQ-014 init_done  output  1  zero-fill complete; high from then until next reset.

Function
REQ-015 FSM states: CLEAR, READY, DEFER.
REQ-016 CLEAR: one array write of zero per cycle at clear counter address, counter 0 to 2^ADDR_WIDTH-1; busy=1, init_done=0.
REQ-017 CLEAR -> READY on the edge writing address 2^ADDR_WIDTH-1; init_done=1 from the next cycle; counter does not wrap.
REQ-018 Requests with busy=1 are dropped: no array write, no mem_rd_valid; initiator holds the request until busy=0.
REQ-019 READY, write only: array[mem_wr_addr] <= mem_wr_data at the sampling edge.
REQ-020 READY, read only: mem_rd_data <= array[mem_rd_addr] at the sampling edge; mem_rd_valid=1 for exactly the following cycle (1-cycle latency).
REQ-021 READY, read and write together (any addresses): write performed at that edge, read address captured in a one-entry pending register, READY -> DEFER; no valid that cycle.
REQ-022 DEFER: busy=1; at next edge array read at pending address into mem_rd_data, mem_rd_valid=1 the following cycle, DEFER -> READY (2-cycle latency).
REQ-023 Collision read to the written address returns the newly written data.
REQ-024 Back-to-back reads in READY give one valid pulse per read, consecutive cycles, in order.
REQ-025 mem_rd_data holds its last value while mem_rd_valid=0.
REQ-026 busy = (state != READY), combinational from the state register.
REQ-027 X on mem_rd/mem_wr while busy=1 does not disturb state.

Reset
REQ-028 On rst_n low: mem_rd_data=0, mem_rd_valid=0, pending register cleared, clear counter=0.
REQ-029 On rst_n low: state=CLEAR, busy=1, init_done=0 if CLEAR_ON_RESET=1; else state=READY, busy=0, init_done=1.
REQ-030 Reset mid-CLEAR restarts fill at address 0; reset in DEFER discards the pending read, no valid issued.
REQ-031 Array contents not reset directly; only the CLEAR fill initialises them.

Structure
REQ-032 Shared package riscv_mem_pkg holds ADDR_WIDTH/DATA_WIDTH defaults and the state enum (CLEAR, READY, DEFER).
REQ-033 Array in one sub-module sp_ram: single port, synchronous write, registered read, one access per cycle.
REQ-034 FSM, clear counter, pending register and arbitration in imem_responder.

Verification
REQ-035 Reset, CLEAR_ON_RESET=1 -> busy=1 for 2048 cycles, init_done=1 after; read addr 0x7FF -> 0x00000000, valid one cycle later.
REQ-036 Write 0x7FF=0xDEADBEEF, then read 0x7FF -> mem_rd_data=0xDEADBEEF, mem_rd_valid pulse 1 cycle after read edge.
REQ-037 Same cycle write 0x010=0x12345678 and read 0x010 -> busy=1 one cycle, valid 2 cycles after, data 0x12345678.
REQ-038 Reads 0x001,0x002,0x003 consecutive after writing 0xA1,0xA2,0xA3 -> three consecutive valid cycles, data in order.
REQ-039 rst_n low at clear counter 0x100 -> fill restarts at 0, busy high 2048 further cycles; rst_n low in DEFER -> no valid pulse.
REQ-040 Write 0x005=0xFFFFFFFF while busy=1 during CLEAR -> address 0x005 reads 0x00000000 after init_done.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// riscv_mem_pkg: shared defaults and FSM state type for the instruction memory responder.
// Contents: ADDR_WIDTH_DEF / DATA_WIDTH_DEF word geometry, state_e (CLEAR, READY, DEFER),
//           and a helper deriving the busy indication from a state value.
package riscv_mem_pkg;

  localparam int ADDR_WIDTH_DEF = 11;
  localparam int DATA_WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,   // zero-filling the array, one word per cycle
    READY = 2'd1,   // accepting read/write requests
    DEFER = 2'd2    // servicing a read postponed by a same-cycle write
  } state_e;

  // The responder only accepts requests in READY.
  function automatic logic state_is_busy(input state_e s);
    return (s != READY);
  endfunction

endpackage : riscv_mem_pkg

// File: rtl/sp_ram.sv
// sp_ram: single-port word array, synchronous write, registered read, one access per cycle.
// Ports: clk, rst_n (resets only the read register), en_i/we_i select read or write,
//        addr_i/wdata_i access address and data, rdata_o registered read data (holds between reads).
module sp_ram #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [0:DEPTH-1];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Array storage has no reset; contents are defined only by writes.
  always_ff @(posedge clk) begin
    if (en_i && we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // Read register updates only on a read access, so it holds its value
  // through write cycles and idle cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (en_i && !we_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule : sp_ram

// File: rtl/imem_responder.sv
// imem_responder: instruction memory responder with post-reset zero fill and read/write arbitration.
// Ports: clk, rst_n; read request mem_rd/mem_rd_addr -> mem_rd_data/mem_rd_valid (1-cycle latency,
//        2 cycles when colliding with a write); write request mem_wr/mem_wr_addr/mem_wr_data;
//        busy (requests dropped while high); init_done (zero fill complete).
module imem_responder
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_rd,
  input  logic [ADDR_WIDTH-1:0] mem_rd_addr,
  output logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  mem_rd_valid,
  input  logic                  mem_wr,
  input  logic [ADDR_WIDTH-1:0] mem_wr_addr,
  input  logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic                  busy,
  output logic                  init_done
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
  localparam state_e RESET_STATE = CLEAR_ON_RESET ? CLEAR : READY;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic [ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  init_done_q, init_done_d;

  // RAM port controls, driven by the output process
  logic                  ram_en;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;

  logic                  clr_last;
  assign clr_last = (clr_cnt_q == LAST_ADDR);

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RESET_STATE;
      clr_cnt_q   <= '0;
      pend_addr_q <= '0;
      rd_valid_q  <= 1'b0;
      init_done_q <= !CLEAR_ON_RESET;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      pend_addr_q <= pend_addr_d;
      rd_valid_q  <= rd_valid_d;
      init_done_q <= init_done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. Request inputs are consulted only in READY so that
  // unknown values on them while busy cannot reach any state.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      CLEAR: begin
        if (clr_last) begin
          state_d = READY;
        end
      end
      READY: begin
        if (mem_rd && mem_wr) begin
          state_d = DEFER;
        end
      end
      DEFER: begin
        state_d = READY;
      end
      default: begin
        state_d = RESET_STATE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output / datapath-control logic
  // ---------------------------------------------------------------------------
  always_comb begin
    ram_en      = 1'b0;
    ram_we      = 1'b0;
    ram_addr    = '0;
    ram_wdata   = '0;
    rd_valid_d  = 1'b0;
    clr_cnt_d   = clr_cnt_q;
    pend_addr_d = pend_addr_q;
    init_done_d = init_done_q;

    unique case (state_q)
      CLEAR: begin
        ram_en   = 1'b1;
        ram_we   = 1'b1;
        ram_addr = clr_cnt_q;
        // Counter stops on the last address rather than wrapping.
        if (clr_last) begin
          init_done_d = 1'b1;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      READY: begin
        if (mem_wr) begin
          // Write wins the single port; a simultaneous read is parked and
          // serviced next cycle, so it observes the freshly written word.
          ram_en    = 1'b1;
          ram_we    = 1'b1;
          ram_addr  = mem_wr_addr;
          ram_wdata = mem_wr_data;
          if (mem_rd) begin
            pend_addr_d = mem_rd_addr;
          end
        end else if (mem_rd) begin
          ram_en     = 1'b1;
          ram_addr   = mem_rd_addr;
          rd_valid_d = 1'b1;
        end
      end
      DEFER: begin
        ram_en     = 1'b1;
        ram_addr   = pend_addr_q;
        rd_valid_d = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign busy = state_is_busy(state_q);

  // ---------------------------------------------------------------------------
  // Word array
  // ---------------------------------------------------------------------------
  sp_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (ram_en),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (mem_rd_data)
  );

  assign mem_rd_valid = rd_valid_q;
  assign init_done    = init_done_q;

endmodule : imem_responder

// File: tb/tb_imem_responder.sv
// tb_imem_responder: directed self-checking bench for imem_responder (default parameters).
// Inputs driven after the falling edge, outputs sampled on the falling edge.
// Covers zero fill, plain read/write, collision deferral, back-to-back reads and resets.
module tb_imem_responder;

  logic        clk;
  logic        rst_n;
  logic        mem_rd;
  logic [10:0] mem_rd_addr;
  logic [31:0] mem_rd_data;
  logic        mem_rd_valid;
  logic        mem_wr;
  logic [10:0] mem_wr_addr;
  logic [31:0] mem_wr_data;
  logic        busy;
  logic        init_done;

  int n_cmp = 0;
  int n_err = 0;

  imem_responder dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_rd       (mem_rd),
    .mem_rd_addr  (mem_rd_addr),
    .mem_rd_data  (mem_rd_data),
    .mem_rd_valid (mem_rd_valid),
    .mem_wr       (mem_wr),
    .mem_wr_addr  (mem_wr_addr),
    .mem_wr_data  (mem_wr_data),
    .busy         (busy),
    .init_done    (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    mem_rd_addr = '0;
    mem_wr_addr = '0;
    mem_wr_data = '0;
  endtask

  // One clock: rising edge, then back to the falling edge for sampling/driving.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Counts cycles spent busy from the current falling edge, bounded.
  // Optionally holds a write to 0x005 and a read request for the first cycles
  // and counts any valid pulses that escape while busy.
  task automatic wait_fill(input int hold_cycles, output int cycles, output int stray_valid);
    cycles      = 0;
    stray_valid = 0;
    while (busy && cycles < 5000) begin
      if (cycles < hold_cycles) begin
        mem_wr      = 1'b1;
        mem_wr_addr = 11'h005;
        mem_wr_data = 32'hFFFF_FFFF;
        mem_rd      = 1'b1;
        mem_rd_addr = 11'h005;
      end else begin
        idle_inputs();
      end
      step();
      cycles++;
      if (mem_rd_valid) stray_valid++;
    end
    idle_inputs();
  endtask

  task automatic do_write(input logic [10:0] a, input logic [31:0] d);
    mem_wr      = 1'b1;
    mem_wr_addr = a;
    mem_wr_data = d;
    step();
    idle_inputs();
  endtask

  task automatic do_read(input string tag, input logic [10:0] a, input logic [31:0] exp);
    mem_rd      = 1'b1;
    mem_rd_addr = a;
    step();
    idle_inputs();
    check({tag, "_valid"}, {31'b0, mem_rd_valid}, 32'd1);
    check({tag, "_data"}, mem_rd_data, exp);
    step();
    check({tag, "_valid_drop"}, {31'b0, mem_rd_valid}, 32'd0);
  endtask

  initial begin
    int cyc;
    int stray;

    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_busy",      {31'b0, busy},         32'd1);
    check("rst_init_done", {31'b0, init_done},    32'd0);
    check("rst_valid",     {31'b0, mem_rd_valid}, 32'd0);
    check("rst_data",      mem_rd_data,           32'd0);

    // Zero fill with dropped requests to 0x005 during the first 100 cycles
    rst_n = 1'b1;
    wait_fill(100, cyc, stray);
    check("fill_cycles",      cyc,   32'd2048);
    check("fill_stray_valid", stray, 32'd0);
    check("fill_init_done",   {31'b0, init_done}, 32'd1);
    check("fill_busy",        {31'b0, busy},      32'd0);

    do_read("rd_7ff_zero", 11'h7FF, 32'h0000_0000);

    do_write(11'h7FF, 32'hDEAD_BEEF);
    do_read("rd_7ff_beef", 11'h7FF, 32'hDEAD_BEEF);

    // Write attempted during fill was dropped
    do_read("rd_005_dropped", 11'h005, 32'h0000_0000);

    // Same-cycle write and read to the same address
    mem_wr      = 1'b1;
    mem_wr_addr = 11'h010;
    mem_wr_data = 32'h1234_5678;
    mem_rd      = 1'b1;
    mem_rd_addr = 11'h010;
    step();
    idle_inputs();
    check("col_busy",  {31'b0, busy},         32'd1);
    check("col_nvld",  {31'b0, mem_rd_valid}, 32'd0);
    step();
    check("col_busy_clr", {31'b0, busy},         32'd0);
    check("col_valid",    {31'b0, mem_rd_valid}, 32'd1);
    check("col_data",     mem_rd_data,           32'h1234_5678);
    step();
    check("col_valid_drop", {31'b0, mem_rd_valid}, 32'd0);
    check("col_data_hold",  mem_rd_data,           32'h1234_5678);

    // Collision with differing addresses returns the read address's content
    mem_wr      = 1'b1;
    mem_wr_addr = 11'h020;
    mem_wr_data = 32'h0000_0055;
    mem_rd      = 1'b1;
    mem_rd_addr = 11'h7FF;
    step();
    idle_inputs();
    check("col2_nvld", {31'b0, mem_rd_valid}, 32'd0);
    step();
    check("col2_valid", {31'b0, mem_rd_valid}, 32'd1);
    check("col2_data",  mem_rd_data,           32'hDEAD_BEEF);
    step();
    do_read("rd_020", 11'h020, 32'h0000_0055);

    // Back-to-back reads
    do_write(11'h001, 32'h0000_00A1);
    do_write(11'h002, 32'h0000_00A2);
    do_write(11'h003, 32'h0000_00A3);
    mem_rd      = 1'b1;
    mem_rd_addr = 11'h001;
    step();
    check("b2b1_valid", {31'b0, mem_rd_valid}, 32'd1);
    check("b2b1_data",  mem_rd_data,           32'h0000_00A1);
    mem_rd_addr = 11'h002;
    step();
    check("b2b2_valid", {31'b0, mem_rd_valid}, 32'd1);
    check("b2b2_data",  mem_rd_data,           32'h0000_00A2);
    mem_rd_addr = 11'h003;
    step();
    idle_inputs();
    check("b2b3_valid", {31'b0, mem_rd_valid}, 32'd1);
    check("b2b3_data",  mem_rd_data,           32'h0000_00A3);
    step();
    check("b2b_end_valid", {31'b0, mem_rd_valid}, 32'd0);
    check("b2b_end_hold",  mem_rd_data,           32'h0000_00A3);

    // Reset mid-fill at counter 0x100
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (256) step();
    check("mid_busy", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", {31'b0, busy},      32'd1);
    check("mid_rst_init", {31'b0, init_done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_fill(0, cyc, stray);
    check("refill_cycles", cyc, 32'd2048);
    do_read("refill_7ff", 11'h7FF, 32'h0000_0000);

    // Reset while in DEFER: no valid pulse afterwards
    mem_wr      = 1'b1;
    mem_wr_addr = 11'h030;
    mem_wr_data = 32'hCAFE_F00D;
    mem_rd      = 1'b1;
    mem_rd_addr = 11'h030;
    step();
    idle_inputs();
    check("defer_busy", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    stray = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (mem_rd_valid) stray++;
    end
    check("defer_rst_valid", stray,       32'd0);
    check("defer_rst_data",  mem_rd_data, 32'd0);
    rst_n = 1'b1;
    wait_fill(0, cyc, stray);
    check("defer_refill", cyc, 32'd2048);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_imem_responder
